morse_key_timer: RTL

- Front-end stage directly upstream of the Morse decoder.
- Synchronises and debounces the raw telegraph key (push button), measures press and gap durations, and classifies each event as dot, dash, letter-end or word-end.
- Buffers the resulting symbols in a 4-entry FIFO and presents them to the decoder over a valid/ready handshake.
- Active only while the converter is in decode mode.

---
 rtl/morse_key_timer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/morse_key_timer.sv
// Morse key front end: synchronise, debounce, time presses/gaps, queue dot/dash/letter/word symbols.
// Optional sidetone output is built only when MORSE_SIDETONE_EN is defined.
module morse_key_timer #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
  parameter int unsigned DOT_MAX_CYCLES    = 25_000_000,
  parameter int unsigned LETTER_GAP_CYCLES = 50_000_000,
  parameter int unsigned WORD_GAP_CYCLES   = 150_000_000,
  parameter int unsigned TONE_HALF_CYCLES  = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       turn_on,
  input  logic       key_in,
  output logic       sym_valid,
  output logic [1:0] sym_code,
  input  logic       sym_ready,
  output logic       key_level,
  output logic       overrun,
  output logic       tone
);

  typedef enum logic [1:0] {StIdle, StPress, StGapInLetter, StGapAfterLetter} state_e;

  localparam logic [1:0] CodeDot    = 2'b00;
  localparam logic [1:0] CodeDash   = 2'b01;
  localparam logic [1:0] CodeLetter = 2'b10;
  localparam logic [1:0] CodeWord   = 2'b11;

  logic        clear;
  logic        sync1_q, sync2_q, key_level_q;
  logic [31:0] deb_cnt_q;

  state_e      state_q, state_d;
  logic [31:0] press_cnt_q, press_cnt_d;
  logic [31:0] gap_cnt_q, gap_cnt_d;
  logic        push;
  logic [1:0]  push_code;

  logic [1:0]  mem_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q;
  logic        overrun_q;
  logic        pop, full, do_wr;

  assign clear = rst | ~turn_on;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // Level follows the synchronised key only after it has differed long enough.
  always_ff @(posedge clk) begin
    if (clear) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      key_level_q <= 1'b0;
      deb_cnt_q   <= '0;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
      if (sync2_q != key_level_q) begin
        if (deb_cnt_q == DEBOUNCE_CYCLES) begin
          key_level_q <= ~key_level_q;
          deb_cnt_q   <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + 32'd1;
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    press_cnt_d = press_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    push        = 1'b0;
    push_code   = CodeDot;
    case (state_q)
      StIdle: begin
        if (key_level_q) begin
          state_d     = StPress;
          press_cnt_d = 32'd1;
        end
      end
      StPress: begin
        if (key_level_q) begin
          press_cnt_d = sat_inc(press_cnt_q);
        end else begin
          push      = 1'b1;
          push_code = (press_cnt_q <= DOT_MAX_CYCLES) ? CodeDot : CodeDash;
          state_d   = StGapInLetter;
          gap_cnt_d = 32'd1;
        end
      end
      StGapInLetter: begin
        if (key_level_q) begin
          state_d     = StPress;
          press_cnt_d = 32'd1;
        end else begin
          gap_cnt_d = sat_inc(gap_cnt_q);
          if (gap_cnt_q == LETTER_GAP_CYCLES) begin
            push      = 1'b1;
            push_code = CodeLetter;
            state_d   = StGapAfterLetter;
          end
        end
      end
      StGapAfterLetter: begin
        if (key_level_q) begin
          state_d     = StPress;
          press_cnt_d = 32'd1;
        end else begin
          gap_cnt_d = sat_inc(gap_cnt_q);
          if (gap_cnt_q == WORD_GAP_CYCLES) begin
            push      = 1'b1;
            push_code = CodeWord;
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= StIdle;
      press_cnt_q <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      press_cnt_q <= press_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign pop   = (count_q != 3'd0) && sym_ready;
  assign full  = (count_q == 3'd4);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_wr = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      if (rst) overrun_q <= 1'b0;
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q] <= push_code;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({do_wr, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
      if (push && full && !pop) overrun_q <= 1'b1;
    end
  end

  assign sym_valid = (count_q != 3'd0);
  assign sym_code  = mem_q[rd_ptr_q];
  assign key_level = key_level_q;
  assign overrun   = overrun_q;

`ifdef MORSE_SIDETONE_EN
  logic [31:0] tone_cnt_q;
  logic        tone_q;

  always_ff @(posedge clk) begin
    if (clear || !key_level_q) begin
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else if (tone_cnt_q == TONE_HALF_CYCLES - 1) begin
      tone_cnt_q <= '0;
      tone_q     <= ~tone_q;
    end else begin
      tone_cnt_q <= tone_cnt_q + 32'd1;
    end
  end

  assign tone = tone_q;
`else
  assign tone = 1'b0;
`endif

endmodule
